// File: rtl/registers_mp.sv
// ID-stage register bank with parametrised read/write ports, optional write->read bypass,
// hardwired zero register and a valid/ready debug-dump engine streaming every register.
module registers_mp #(
   parameter int REGISTERS_BANK_SIZE = 32,
   parameter int REGISTERS_SIZE      = 32,
   parameter int READ_PORTS          = 2,
   parameter int WRITE_PORTS         = 1,
   parameter int BYPASS              = 1,
   localparam int AW = $clog2(REGISTERS_BANK_SIZE),
   localparam int W  = REGISTERS_SIZE
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_flush,
   input  logic [WRITE_PORTS-1:0]      i_wr_en,
   input  logic [WRITE_PORTS*AW-1:0]   i_wr_addr,
   input  logic [WRITE_PORTS*W-1:0]    i_wr_data,
   input  logic [READ_PORTS*AW-1:0]    i_rd_addr,
   output logic [READ_PORTS*W-1:0]     o_rd_data,
   input  logic                        i_dump_start,
   input  logic                        i_dump_ready,
   output logic                        o_dump_valid,
   output logic [AW-1:0]               o_dump_addr,
   output logic [W-1:0]                o_dump_data,
   output logic                        o_dump_busy,
   output logic                        o_dump_done
);

   // Dump handshake: a beat transfers on a rising edge where o_dump_valid & i_dump_ready;
   // while i_dump_ready is low the presented address is held (data tracks the stored value).
   typedef enum logic {S_IDLE = 1'b0, S_DUMP = 1'b1} state_e;

   localparam logic [AW-1:0] LAST_IDX = AW'(REGISTERS_BANK_SIZE - 1);

   logic [W-1:0]  regs_q [REGISTERS_BANK_SIZE];
   logic [W-1:0]  regs_d [REGISTERS_BANK_SIZE];
   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          done_q, done_d;
   logic          clear;

   assign clear = i_reset | i_flush;

   // Ascending port order lets the highest-index port win an address collision.
   always_comb begin
      regs_d = regs_q;
      for (int p = 0; p < WRITE_PORTS; p++) begin
         if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] != '0)) begin
            regs_d[i_wr_addr[p*AW +: AW]] = i_wr_data[p*W +: W];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (clear) begin
         for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic [W-1:0]  rv;
      assign ra = i_rd_addr[k*AW +: AW];
      always_comb begin
         rv = (ra == '0) ? '0 : regs_q[ra];
         if ((BYPASS != 0) && (ra != '0)) begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
               if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == ra)) begin
                  rv = i_wr_data[p*W +: W];
               end
            end
         end
      end
      assign o_rd_data[k*W +: W] = rv;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_dump_start) begin
               state_d = S_DUMP;
               idx_d   = '0;
            end
         end
         S_DUMP: begin
            if (i_dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (clear) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Dump data is always the stored value, never the bypassed one.
   assign o_dump_valid = (state_q == S_DUMP);
   assign o_dump_busy  = (state_q == S_DUMP);
   assign o_dump_addr  = o_dump_valid ? idx_q : '0;
   assign o_dump_data  = (o_dump_valid && (idx_q != '0)) ? regs_q[idx_q] : '0;
   assign o_dump_done  = done_q;

endmodule

// File: tb/tb_registers_mp.sv
// Directed bench for registers_mp: table of read/write vectors plus hand-written dump,
// backpressure, reset and flush sequences.
module tb_registers_mp;

   localparam int N  = 32;
   localparam int W  = 32;
   localparam int R  = 2;
   localparam int P  = 2;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset, flush;
   logic [P-1:0]  wr_en;
   logic [P*AW-1:0] wr_addr;
   logic [P*W-1:0]  wr_data;
   logic [R*AW-1:0] rd_addr;
   logic [R*W-1:0]  rd_data;
   logic          dump_start, dump_ready;
   logic          dump_valid, dump_busy, dump_done;
   logic [AW-1:0] dump_addr;
   logic [W-1:0]  dump_data;

   int checks   = 0;
   int failures = 0;

   registers_mp #(
      .REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(W), .READ_PORTS(R),
      .WRITE_PORTS(P), .BYPASS(1)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_flush(flush),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rd_addr(rd_addr), .o_rd_data(rd_data),
      .i_dump_start(dump_start), .i_dump_ready(dump_ready),
      .o_dump_valid(dump_valid), .o_dump_addr(dump_addr), .o_dump_data(dump_data),
      .o_dump_busy(dump_busy), .o_dump_done(dump_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  en;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; flush = 0; wr_en = '0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; dump_start = 0; dump_ready = 0;
   endtask

   task automatic check_dump_idle(input string tag);
      check({tag, "_valid"}, 64'(dump_valid), 64'd0);
      check({tag, "_busy"},  64'(dump_busy),  64'd0);
      check({tag, "_addr"},  64'(dump_addr),  64'd0);
      check({tag, "_data"},  64'(dump_data),  64'd0);
   endtask

   initial begin
      int beats;
      int busy_cycles;
      int done_seen;

      vecs[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
      vecs[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  5'd5,  5'd1,  32'hDEADBEEF, 32'h0};
      vecs[2]  = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22, 5'd7,  5'd7,  32'h22,       32'h22};
      vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  5'd7,  5'd5,  32'h22,       32'hDEADBEEF};
      vecs[4]  = '{2'b01, 5'd0,  32'hFF,       5'd0,  32'h0,  5'd0,  5'd7,  32'h0,        32'h22};
      vecs[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  5'd0,  5'd7,  32'h0,        32'h22};
      vecs[6]  = '{2'b10, 5'd0,  32'h0,        5'd3,  32'h10, 5'd3,  5'd2,  32'h10,       32'h0};
      vecs[7]  = '{2'b01, 5'd3,  32'h55,       5'd0,  32'h0,  5'd3,  5'd4,  32'h55,       32'h0};
      vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  5'd3,  5'd3,  32'h55,       32'h55};
      vecs[9]  = '{2'b11, 5'd9,  32'hA,        5'd10, 32'hB,  5'd9,  5'd10, 32'hA,        32'hB};
      vecs[10] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  5'd9,  5'd10, 32'hA,        32'hB};

      // Clock/reset
      idle_inputs();
      reset = 1;
      tick(); tick();
      reset = 0;
      rd_addr = {5'd1, 5'd5};
      #1;
      check("rst_rd0", 64'(rd_data[31:0]), 64'd0);
      check_dump_idle("rst_dump");
      check("rst_done", 64'(dump_done), 64'd0);

      // Read/write vector table
      for (int v = 0; v < 11; v++) begin
         wr_en   = vecs[v].en;
         wr_addr = {vecs[v].wa1, vecs[v].wa0};
         wr_data = {vecs[v].wd1, vecs[v].wd0};
         rd_addr = {vecs[v].ra1, vecs[v].ra0};
         #1;
         check($sformatf("vec%0d_rd0", v), 64'(rd_data[31:0]),  64'(vecs[v].e0));
         check($sformatf("vec%0d_rd1", v), 64'(rd_data[63:32]), 64'(vecs[v].e1));
         tick();
      end
      idle_inputs();

      // Reset with a simultaneous write and dump start: both discarded
      reset = 1; wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h77}; dump_start = 1;
      tick();
      idle_inputs();
      rd_addr = {5'd9, 5'd5};
      #1;
      check("reset_r5", 64'(rd_data[31:0]),  64'd0);
      check("reset_r9", 64'(rd_data[63:32]), 64'd0);
      check_dump_idle("reset_dump");
      check("reset_done", 64'(dump_done), 64'd0);

      // Preset r[i] = i*3
      for (int i = 1; i < N; i++) begin
         wr_en = 2'b01; wr_addr = {5'd0, 5'(i)}; wr_data = {32'h0, 32'(i * 3)};
         tick();
      end
      idle_inputs();

      // Full dump with ready held high
      dump_start = 1; dump_ready = 1;
      tick();
      dump_start = 0;
      busy_cycles = 0;
      for (int c = 0; c < N; c++) begin
         #1;
         check($sformatf("dump_valid_%0d", c), 64'(dump_valid), 64'd1);
         check($sformatf("dump_addr_%0d", c),  64'(dump_addr),  64'(c));
         check($sformatf("dump_data_%0d", c),  64'(dump_data),  64'(c * 3));
         if (dump_busy) busy_cycles++;
         if (dump_done) check($sformatf("dump_early_done_%0d", c), 64'(dump_done), 64'd0);
         tick();
      end
      check("dump_busy_cycles", 64'(busy_cycles), 64'(N));
      check("dump_done_pulse", 64'(dump_done), 64'd1);
      check("dump_end_valid", 64'(dump_valid), 64'd0);
      check("dump_end_busy", 64'(dump_busy), 64'd0);
      dump_ready = 0;
      tick();
      check("dump_done_oneshot", 64'(dump_done), 64'd0);

      // Backpressure, held-register write, ignored restart
      dump_start = 1;
      tick();
      dump_start = 0; dump_ready = 1;
      check("bp_addr0", 64'(dump_addr), 64'd0);
      tick();
      dump_ready = 0; dump_start = 1;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd1}; wr_data = {32'h0, 32'h1234};
      #1;
      check("bp_hold_addr", 64'(dump_addr), 64'd1);
      check("bp_hold_old_data", 64'(dump_data), 64'd3);
      tick();
      idle_inputs();
      #1;
      check("bp_restart_ignored", 64'(dump_addr), 64'd1);
      check("bp_new_data", 64'(dump_data), 64'h1234);
      check("bp_still_valid", 64'(dump_valid), 64'd1);
      tick();
      dump_ready = 1;
      check("bp_resume_addr", 64'(dump_addr), 64'd1);
      tick();
      check("bp_next_addr", 64'(dump_addr), 64'd2);
      check("bp_next_data", 64'(dump_data), 64'd6);
      for (int i = 0; i < 64 && !dump_done; i++) tick();
      check("bp_done", 64'(dump_done), 64'd1);

      // Start accepted in the done-pulse cycle
      dump_start = 1;
      tick();
      dump_start = 0;
      check("restart_busy", 64'(dump_busy), 64'd1);
      check("restart_addr", 64'(dump_addr), 64'd0);

      // Flush at beat 10
      for (int i = 0; i < 10; i++) tick();
      check("flush_pre_addr", 64'(dump_addr), 64'd10);
      check("flush_pre_data", 64'(dump_data), 64'd30);
      flush = 1;
      tick();
      flush = 0;
      rd_addr = {5'd1, 5'd7};
      #1;
      check_dump_idle("flush_dump");
      check("flush_done", 64'(dump_done), 64'd0);
      check("flush_r7", 64'(rd_data[31:0]),  64'd0);
      check("flush_r1", 64'(rd_data[63:32]), 64'd0);
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (dump_done) done_seen++;
      end
      check("flush_no_done", 64'(done_seen), 64'd0);

      // Fresh dump after flush: 32 beats of zeros, then done
      dump_start = 1;
      tick();
      dump_start = 0;
      beats = 0; done_seen = 0;
      for (int i = 0; i < 100 && done_seen == 0; i++) begin
         if (dump_valid) begin
            if (dump_data != '0 || dump_addr != 5'(beats))
               check($sformatf("fresh_beat_%0d", beats), {27'd0, dump_addr, dump_data}, {27'd0, 5'(beats), 32'd0});
            beats++;
         end
         tick();
         if (dump_done) done_seen++;
      end
      check("fresh_beats", 64'(beats), 64'(N));
      check("fresh_done", 64'(done_seen), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
